// File: rtl/lcd_clock_sequencer.sv
// Power-up/recovery sequencer for the LCD pixel-clock PLL, panel enable and backlight.
// Optional: define LCD_SEQ_LOCK_LOSS_COUNT_EN to add the saturating lock_loss_count output.
module lcd_clock_sequencer #(
  parameter int unsigned PLL_RESET_CYCLES       = 16,
  parameter int unsigned LOCK_STABLE_CYCLES     = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES    = 65535,
  parameter int unsigned MAX_RETRIES            = 3,
  parameter int unsigned BACKLIGHT_DELAY_CYCLES = 12000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       pixel_reset,
  output logic       disp_en,
  output logic       backlight_en,
  output logic       ready,
`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
  output logic [7:0] lock_loss_count,
`endif
  output logic       error
);

  localparam int unsigned M1    = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned M2    = (M1 > LOCK_TIMEOUT_CYCLES) ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned M3    = (M2 > MAX_RETRIES) ? M2 : MAX_RETRIES;
  localparam int unsigned MAX_P = (M3 > BACKLIGHT_DELAY_CYCLES) ? M3 : BACKLIGHT_DELAY_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  // A state with length N is left on the edge where its counter shows N-1.
  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST     = CW'(BACKLIGHT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_MAX   = CW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE, PLL_RST, WAIT_LOCK, DISP_ON, RUN, BL_OFF, FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stab_q, stab_d;
  logic [CW-1:0] retry_q, retry_d;
  logic [CW-1:0] retry_inc;
  logic          sync1_q, lock_s_q;
  logic          pll_resetb_q, pixel_reset_q, disp_en_q, backlight_en_q, ready_q, error_q;
  logic          pll_resetb_d, pixel_reset_d, disp_en_d, backlight_en_d, ready_d, error_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + CW'(1);
    case (state_q)
      IDLE: begin
        retry_d = '0;
        if (enable) state_d = PLL_RST;
      end
      PLL_RST: begin
        if (!enable)                state_d = IDLE;
        else if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (lock_s_q && (stab_q == STABLE_LAST)) begin
          state_d = DISP_ON;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
        end
      end
      DISP_ON: begin
        if (!lock_s_q)             state_d = PLL_RST;
        else if (!enable)          state_d = IDLE;
        else if (cnt_q == BL_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q)    state_d = PLL_RST;
        else if (!enable) state_d = BL_OFF;
      end
      BL_OFF: begin
        if (cnt_q == BL_LAST) state_d = IDLE;
      end
      FAULT: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == RUN) && (state_q != RUN)) retry_d = '0;

    cnt_d = (state_d != state_q) ? '0 : sat_inc(cnt_q);
    if ((state_d != state_q) || (state_q != WAIT_LOCK)) stab_d = '0;
    else if (lock_s_q)                                   stab_d = sat_inc(stab_q);
    else                                                 stab_d = '0;

    // Outputs follow the next state so they switch on the same edge as the state.
    pll_resetb_d   = (state_d == WAIT_LOCK) || (state_d == DISP_ON) ||
                     (state_d == RUN) || (state_d == BL_OFF);
    disp_en_d      = (state_d == DISP_ON) || (state_d == RUN) || (state_d == BL_OFF);
    pixel_reset_d  = !disp_en_d;
    backlight_en_d = (state_d == RUN);
    ready_d        = (state_d == RUN);
    error_d        = (state_d == FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stab_q         <= '0;
      retry_q        <= '0;
      pll_resetb_q   <= 1'b0;
      pixel_reset_q  <= 1'b1;
      disp_en_q      <= 1'b0;
      backlight_en_q <= 1'b0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stab_q         <= stab_d;
      retry_q        <= retry_d;
      pll_resetb_q   <= pll_resetb_d;
      pixel_reset_q  <= pixel_reset_d;
      disp_en_q      <= disp_en_d;
      backlight_en_q <= backlight_en_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign pixel_reset  = pixel_reset_q;
  assign disp_en      = disp_en_q;
  assign backlight_en = backlight_en_q;
  assign ready        = ready_q;
  assign error        = error_q;

`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
  logic [7:0] llc_q;
  logic       lost;

  assign lost = ((state_q == DISP_ON) || (state_q == RUN)) && !lock_s_q;

  always_ff @(posedge clock) begin
    if (reset)                       llc_q <= 8'd0;
    else if (lost && llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
  end

  assign lock_loss_count = llc_q;
`endif

endmodule

// File: tb/tb_lcd_clock_sequencer.sv
// Scoreboard bench for lcd_clock_sequencer: per-cycle expected output vectors are queued, then popped and compared.
module tb_lcd_clock_sequencer;

  logic clock = 1'b0;
  logic reset, enable, pll_locked;
  logic pll_resetb, pixel_reset, disp_en, backlight_en, ready, error;
`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int total = 0;
  int bad   = 0;

  // {pll_resetb, pixel_reset, disp_en, backlight_en, ready, error}
  localparam logic [5:0] V_IDLE  = 6'b010000;
  localparam logic [5:0] V_PRST  = 6'b010000;
  localparam logic [5:0] V_WAIT  = 6'b110000;
  localparam logic [5:0] V_DISP  = 6'b101000;
  localparam logic [5:0] V_RUN   = 6'b101110;
  localparam logic [5:0] V_BLOFF = 6'b101000;
  localparam logic [5:0] V_FAULT = 6'b010001;

  logic [5:0] obs;
  logic [5:0] exp_v;
  logic [5:0] exp_q[$];

  assign obs = {pll_resetb, pixel_reset, disp_en, backlight_en, ready, error};

  always #5 clock = ~clock;

  lcd_clock_sequencer #(
    .PLL_RESET_CYCLES      (4),
    .LOCK_STABLE_CYCLES    (8),
    .LOCK_TIMEOUT_CYCLES   (32),
    .MAX_RETRIES           (2),
    .BACKLIGHT_DELAY_CYCLES(5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .pll_locked  (pll_locked),
    .pll_resetb  (pll_resetb),
    .pixel_reset (pixel_reset),
    .disp_en     (disp_en),
    .backlight_en(backlight_en),
    .ready       (ready),
`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
    .lock_loss_count(lock_loss_count),
`endif
    .error       (error)
  );

  task automatic push_seg(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Holds reset for 3 edges; the next posedge (P0) still sees reset, then enable is raised.
  task automatic start_seq(input logic lk, input logic en);
    reset = 1'b1; enable = 1'b0; pll_locked = lk;
    repeat (3) @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0; enable = en;
  endtask

  task automatic test_reset;
    exp_q.delete();
    reset = 1'b1; enable = 1'b0; pll_locked = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (obs !== V_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", obs, V_IDLE);
    end
    push_seg(V_IDLE, 4);
    #1 reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_idle_hold c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_nominal;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 8); push_seg(V_DISP, 5); push_seg(V_RUN, 5);
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL nominal c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_lock_glitch;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 15); push_seg(V_DISP, 5); push_seg(V_RUN, 3);
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 27; c++) begin
      @(posedge clock); #1;
      if (c == 9)  pll_locked = 1'b0;
      if (c == 10) pll_locked = 1'b1;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lock_glitch c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout_fault;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 32); push_seg(V_PRST, 4); push_seg(V_WAIT, 32);
    push_seg(V_FAULT, 4); push_seg(V_IDLE, 3);
    start_seq(1'b0, 1'b1);
    for (int c = 1; c <= 79; c++) begin
      @(posedge clock); #1;
      if (c == 76) enable = 1'b0;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL timeout_fault c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_lock_loss;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 8); push_seg(V_DISP, 5); push_seg(V_RUN, 7);
    push_seg(V_PRST, 4); push_seg(V_WAIT, 8); push_seg(V_DISP, 5); push_seg(V_RUN, 3);
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 44; c++) begin
      @(posedge clock); #1;
      if (c == 22) pll_locked = 1'b0;
      if (c == 26) pll_locked = 1'b1;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lock_loss c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
    total++;
    if (lock_loss_count !== 8'd1) begin
      bad++;
      $display("FAIL lock_loss_count: got %0d want 1", lock_loss_count);
    end
`endif
  endtask

  task automatic test_power_down;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 8); push_seg(V_DISP, 5); push_seg(V_RUN, 3);
    push_seg(V_BLOFF, 5); push_seg(V_IDLE, 4);
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 29; c++) begin
      @(posedge clock); #1;
      if (c == 20) enable = 1'b0;
      if (c == 22) enable = 1'b1;
      if (c == 23) enable = 1'b0;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL power_down c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_disp;
    exp_q.delete();
    push_seg(V_PRST, 4); push_seg(V_WAIT, 8); push_seg(V_DISP, 2); push_seg(V_IDLE, 4);
    push_seg(V_PRST, 1);
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 19; c++) begin
      @(posedge clock); #1;
      if (c == 14) reset = 1'b1;
      if (c == 15) begin reset = 1'b0; enable = 1'b0; end
      if (c == 18) enable = 1'b1;
      @(negedge clock);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_disp c=%0d: got %b want %b", c, obs, exp_v);
      end
    end
`ifdef LCD_SEQ_LOCK_LOSS_COUNT_EN
    total++;
    if (lock_loss_count !== 8'd0) begin
      bad++;
      $display("FAIL lock_loss_count_after_reset: got %0d want 0", lock_loss_count);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pll_locked = 1'b0;
    test_reset;
    test_nominal;
    test_lock_glitch;
    test_timeout_fault;
    test_lock_loss;
    test_power_down;
    test_reset_mid_disp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
